// File: rtl/pool_pkg.sv
// pool_pkg: shared FSM state type, default geometry and derived frame sizes for the pooling controller.
package pool_pkg;
  localparam int DW_DEF    = 8;
  localparam int IMG_W_DEF = 6;
  localparam int IMG_H_DEF = 6;
  localparam int N_IN      = IMG_W_DEF * IMG_H_DEF;
  localparam int N_OUT     = (IMG_W_DEF / 2) * (IMG_H_DEF / 2);
  typedef enum logic [2:0] {IDLE, CLEAR, GAP, FEED, DRAIN, FIN} state_t;
endpackage

// File: rtl/pool_if.sv
// pool_if: pixel stream, pooler control/result and frame status signals of the pooling controller.
interface pool_if
  import pool_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          pool_ce;
  logic          pool_rst;
  logic [DW-1:0] pool_din;
  logic [DW-1:0] pool_dout;
  logic          pool_valid;
  logic          pool_end;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          frame_err;
  modport slave (
    input  start, in_valid, in_data, pool_dout, pool_valid, pool_end,
    output in_ready, pool_ce, pool_rst, pool_din, out_valid, out_data, out_last, busy, done, frame_err
  );
  modport master (
    output start, in_valid, in_data, pool_dout, pool_valid, pool_end,
    input  in_ready, pool_ce, pool_rst, pool_din, out_valid, out_data, out_last, busy, done, frame_err
  );
endinterface

// File: rtl/pooler.sv
// pooler: 2x2 max-pool over a row-major stream; result registered, pool_end pulses one cycle after the final result.
module pooler
  import pool_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic          clk,
  input  logic          master_rst,
  input  logic          ce,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          pool_end
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          fin;
  logic          acc;
  logic [DW-1:0] hold;
  logic [DW-1:0] m;
  logic [DW-1:0] up;
  logic [DW-1:0] line [IMG_W/2];
  assign acc = ce && !fin;
  assign m   = hold > din ? hold : din;
  assign up  = line[col[CW-1:1]];
  // once the whole frame is consumed, further enables only flush and are ignored
  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      col      <= '0;
      row      <= '0;
      fin      <= 1'b0;
      hold     <= '0;
      dout     <= '0;
      valid    <= 1'b0;
      pool_end <= 1'b0;
    end else begin
      valid    <= acc && col[0] && row[0];
      pool_end <= valid && fin;
      if (acc) begin
        hold <= din;
        if (col[0] && row[0]) dout <= up > m ? up : m;
        col <= col == CW'(IMG_W - 1) ? '0 : col + 1'b1;
        if (col == CW'(IMG_W - 1)) row <= row == RW'(IMG_H - 1) ? '0 : row + 1'b1;
        fin <= col == CW'(IMG_W - 1) && row == RW'(IMG_H - 1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (acc && col[0] && !row[0]) line[col[CW-1:1]] <= m;
  end
endmodule

// File: rtl/pool_ctrl.sv
// pool_ctrl: frame sequencer that clears, feeds and drains an external pooler and re-times its results.
module pool_ctrl
  import pool_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int DRAIN_MAX = 16
) (
  input logic  clk,
  input logic  master_rst,
  pool_if.slave bus
);
  localparam int IN_TOT  = IMG_W * IMG_H;
  localparam int OUT_TOT = (IMG_W / 2) * (IMG_H / 2);
  localparam int IW      = $clog2(IN_TOT + 1);
  localparam int OW      = $clog2(OUT_TOT + 1);
  localparam int DCW     = $clog2(DRAIN_MAX + 1);
  state_t         state, nxt;
  logic [IW-1:0]  in_cnt;
  logic [OW-1:0]  out_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           accept, run, last_in, timeout;
  assign accept  = state == FEED && bus.in_valid;
  assign run     = state == FEED || state == DRAIN;
  assign last_in = accept && in_cnt == IW'(IN_TOT - 1);
  assign timeout = state == DRAIN && drain_cnt == DCW'(DRAIN_MAX - 1);
  assign bus.in_ready = state == FEED;
  assign bus.pool_ce  = accept || state == DRAIN;
  assign bus.pool_rst = master_rst || state == CLEAR;
  assign bus.pool_din = bus.in_data;
  assign bus.busy     = state != IDLE;
  assign bus.done     = state == FIN;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = bus.start ? CLEAR : IDLE;
      CLEAR:   nxt = GAP;
      GAP:     nxt = FEED;
      FEED:    nxt = last_in ? DRAIN : FEED;
      DRAIN:   nxt = bus.out_last || bus.pool_end || timeout ? FIN : DRAIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      in_cnt        <= '0;
      out_cnt       <= '0;
      drain_cnt     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        in_cnt    <= '0;
        out_cnt   <= '0;
        drain_cnt <= '0;
      end else begin
        if (accept) in_cnt <= in_cnt + 1'b1;
        if (run && bus.pool_valid) out_cnt <= out_cnt + 1'b1;
        if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      end
      bus.out_valid <= run && bus.pool_valid;
      bus.out_last  <= run && bus.pool_valid && out_cnt == OW'(OUT_TOT - 1);
      if (run && bus.pool_valid) bus.out_data <= bus.pool_dout;
      // an accepted start clears the flag; a start while busy sets it
      if (bus.start) bus.frame_err <= state != IDLE;
      else if (timeout) bus.frame_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pool_ctrl.sv
// tb_pool_ctrl: directed frames through pool_ctrl plus a 2x2 max pooler, results checked against a queue of expected pooled pixels.
module tb_pool_ctrl;
  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;
  logic       clk = 1'b0;
  logic       master_rst;
  logic       mute;
  logic [7:0] p_dout;
  logic       p_valid, p_end;
  int         cyc = 0;
  int         nassert = 0;
  int         nfail = 0;
  int         last_cyc, rst_cyc, ce_cyc, acc_cyc;
  exp_t       exp_q[$];
  pool_if #(.DW(8)) bus ();
  pool_ctrl #(.DW(8), .IMG_W(6), .IMG_H(6), .DRAIN_MAX(16)) dut (
    .clk(clk), .master_rst(master_rst), .bus(bus)
  );
  pooler #(.DW(8), .IMG_W(6), .IMG_H(6)) u_pool (
    .clk(clk), .master_rst(bus.pool_rst), .ce(bus.pool_ce), .din(bus.pool_din),
    .dout(p_dout), .valid(p_valid), .pool_end(p_end)
  );
  assign bus.pool_dout  = p_dout;
  assign bus.pool_valid = p_valid & ~mute;
  assign bus.pool_end   = p_end & ~mute;
  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] pix(input bit rev, input int k);
    return rev ? 8'(36 - k) : 8'(k + 1);
  endfunction
  task automatic push_frame(input bit rev);
    logic [7:0] m, v;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        m = 0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            v = pix(rev, (2 * r + dr) * 6 + 2 * c + dc);
            if (v > m) m = v;
          end
        exp_q.push_back('{d: m, l: (r == 2 && c == 2)});
      end
  endtask
  task automatic chk_reset();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_pool_ce", bus.pool_ce, 0);
    chk("rst_pool_rst", bus.pool_rst, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_frame_err", bus.frame_err, 0);
  endtask
  always @(negedge clk) begin
    if (!master_rst) begin
      if (bus.out_valid) begin
        chk("out_queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e.d);
          chk("out_last", bus.out_last, e.l);
        end
        if (bus.out_last) last_cyc = cyc;
      end
      if (bus.pool_rst) rst_cyc = cyc;
      if (bus.pool_ce && ce_cyc == -1) ce_cyc = cyc;
    end
  end
  task automatic run_frame(input bit rev, input int gap_at, input int abort_at, input int start_at);
    int  k, gap, t;
    bit  sp;
    ce_cyc = -1; rst_cyc = -1; last_cyc = -1; acc_cyc = -1;
    k = 0; gap = 0; t = 0; sp = 0;
    if (!mute) push_frame(rev);
    @(negedge clk);
    bus.start = 1; bus.in_valid = 1; bus.in_data = pix(rev, 0);
    @(negedge clk);
    bus.start = 0;
    chk("err_clear_on_start", bus.frame_err, 0);
    chk("busy_in_frame", bus.busy, 1);
    while (k < 36 && !(abort_at != 0 && k >= abort_at) && t < 400) begin
      if (gap > 0) begin
        bus.in_valid = 0;
        gap--;
      end else begin
        bus.in_valid = 1;
        bus.in_data = pix(rev, k);
      end
      bus.start = start_at != 0 && k == start_at && !sp;
      if (bus.start) sp = 1;
      #1;
      if (!bus.in_valid) chk("gap_pool_ce", bus.pool_ce, 0);
      if (bus.in_valid && bus.in_ready) begin
        k++;
        acc_cyc = cyc;
        if (k == gap_at) gap = 3;
      end
      @(negedge clk);
      t++;
    end
    bus.in_valid = 0;
    bus.start = 0;
    chk("feed_bound", k, abort_at != 0 ? abort_at : 36);
    if (abort_at != 0) begin
      #5 master_rst = 1;
      #1 chk_reset();
      exp_q.delete();
      @(negedge clk) master_rst = 0;
      return;
    end
    t = 0;
    while (!bus.done && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", bus.done, 1);
    chk("rst_to_ce", ce_cyc - rst_cyc, 2);
    chk("frame_err_at_done", bus.frame_err, (mute || start_at != 0) ? 1 : 0);
    if (mute) chk("drain_timeout_len", cyc - acc_cyc, 17);
    else begin
      chk("done_after_last", cyc - last_cyc, 1);
      chk("queue_drained", exp_q.size(), 0);
    end
    @(negedge clk);
    chk("idle_after_fin", bus.busy, 0);
    chk("done_pulse", bus.done, 0);
  endtask
  initial begin
    master_rst = 1; mute = 0;
    bus.start = 0; bus.in_valid = 0; bus.in_data = 0;
    #1 chk_reset();
    #100;
    @(negedge clk) master_rst = 0;
    chk("idle_after_release", bus.busy, 0);
    run_frame(0, 0, 0, 0);
    @(negedge clk) master_rst = 1;
    #1 chk_reset();
    @(negedge clk) master_rst = 0;
    run_frame(1, 0, 0, 0);
    run_frame(0, 12, 0, 0);
    mute = 1;
    run_frame(0, 0, 0, 0);
    mute = 0;
    run_frame(0, 0, 0, 0);
    run_frame(0, 0, 20, 0);
    run_frame(0, 0, 0, 0);
    run_frame(0, 0, 0, 5);
    run_frame(1, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end
endmodule
